// File: rtl/ddr_package.sv
// Types shared between the host-side stimulus and the DDR controller:
// the request record carried through the request queue and the
// READ/WRITE encoding, plus default sizing for the request queue.
package ddr_package;

  typedef enum logic {
    WRITE = 1'b0,
    READ  = 1'b1
  } rw_type;

  typedef struct packed {
    logic [31:0] physical_addr;
    logic [63:0] data_wr;
    rw_type      rw;
  } input_data_type;

  localparam int REQ_Q_DEPTH_DEF   = 8;
  localparam int REQ_Q_MIN_GAP_DEF = 8;

endpackage

// File: rtl/ddr_req_fifo.sv
// In-order synchronous FIFO for DDR request records.
// Pointers carry one extra wrap bit so full and empty can be told apart
// without a separate occupancy register; occupancy is the pointer difference.
// Pushes while full and pops while empty are ignored, so a held request is
// never lost or overwritten.
module ddr_req_fifo
  import ddr_package::*;
#(
  parameter int DEPTH = REQ_Q_DEPTH_DEF
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  input_data_type         wdata_i,
  input  logic                   pop_i,
  output input_data_type         rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]    wr_ptr_q, wr_ptr_d;
  logic [AW:0]    rd_ptr_q, rd_ptr_d;
  logic           do_push;
  logic           do_pop;
  input_data_type mem_q [DEPTH];

  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign count_o = wr_ptr_q - rd_ptr_q;

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  assign wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
  assign rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};

  // Head entry is read combinationally; no bypass from the write port.
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

  // Pointer registers; reset empties the FIFO.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage array; contents need no reset since the pointers gate visibility.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end
  end

endmodule

// File: rtl/ddr_req_queue.sv
// Request queue in front of the DDR burst pipeline. Requests are buffered
// in order and issued one at a time as a single-cycle act_cmd strobe with
// the request on data_out. After every issue the queue waits MIN_GAP cycles
// (ignoring dev_busy) so the controller has time to raise dev_busy; while
// idle, a high dev_busy holds off issue indefinitely.
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both high. req_ready is !full and depends only on queue
// state; while it is low the host keeps req_valid and req_data stable.
module ddr_req_queue
  import ddr_package::*;
#(
  parameter int DEPTH   = REQ_Q_DEPTH_DEF,
  parameter int MIN_GAP = REQ_Q_MIN_GAP_DEF,
  parameter int CNT_W   = 16
) (
  input  logic                   clock_n,
  input  logic                   reset_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  input_data_type         req_data,
  input  logic                   dev_busy,
  output logic                   act_cmd,
  output input_data_type         data_out,
  output logic [$clog2(DEPTH):0] q_count,
  output logic                   q_empty,
  output logic [CNT_W-1:0]       issued_cnt,
  output logic                   dbg_state
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_GAP  = 1'b1
  } state_e;

  // Gap counter holds MIN_GAP-1 down to 0.
  localparam int GW = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;
  localparam logic [GW-1:0] GAP_INIT = GW'(MIN_GAP - 1);

  state_e           state_q, state_d;
  logic [GW-1:0]    gap_q, gap_d;
  logic             issue;

  logic             act_q, act_d;
  input_data_type   data_q, data_d;
  logic [CNT_W-1:0] issued_q, issued_d;

  logic             fifo_full;
  logic             fifo_empty;
  input_data_type   fifo_head;

  ddr_req_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clock_n),
    .rst_ni  (reset_n),
    .push_i  (req_valid),
    .wdata_i (req_data),
    .pop_i   (issue),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (q_count)
  );

  assign req_ready  = !fifo_full;
  assign q_empty    = fifo_empty;
  assign act_cmd    = act_q;
  assign data_out   = data_q;
  assign issued_cnt = issued_q;
  assign dbg_state  = state_q;

  // Issue FSM state and gap counter.
  always_ff @(posedge clock_n or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
    end
  end

  // Next state: issue from IDLE when a request is waiting and the
  // controller is free, then sit out the gap before looking again.
  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    issue   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty && !dev_busy) begin
          issue   = 1'b1;
          state_d = ST_GAP;
          gap_d   = GAP_INIT;
        end
      end
      ST_GAP: begin
        if (gap_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          gap_d = gap_q - GW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        gap_d   = '0;
      end
    endcase
  end

  // Output next values: strobe, captured head entry, issue count.
  always_comb begin
    act_d    = issue;
    data_d   = data_q;
    issued_d = issued_q;
    if (issue) begin
      data_d   = fifo_head;
      issued_d = issued_q + CNT_W'(1);
    end
  end

  // Output registers; act_cmd clears asynchronously on reset.
  always_ff @(posedge clock_n or negedge reset_n) begin
    if (!reset_n) begin
      act_q    <= 1'b0;
      data_q   <= '0;
      issued_q <= '0;
    end else begin
      act_q    <= act_d;
      data_q   <= data_d;
      issued_q <= issued_d;
    end
  end

endmodule

// File: tb/tb_ddr_req_queue.sv
// Bench for ddr_req_queue: directed scenarios plus a randomized run, all
// checked every cycle against a queue-and-timestamp model of the queue.
module tb_ddr_req_queue;
  import ddr_package::*;

  localparam int DEPTH   = 8;
  localparam int MIN_GAP = 8;
  localparam int CNT_W   = 4;
  localparam int W       = $bits(input_data_type);

  // ---------------- clock / reset ----------------
  logic           clock_n   = 1'b0;
  logic           reset_n   = 1'b0;
  logic           req_valid = 1'b0;
  input_data_type req_data  = '0;
  logic           dev_busy  = 1'b0;

  logic             req_ready;
  logic             act_cmd;
  input_data_type   data_out;
  logic [3:0]       q_count;
  logic             q_empty;
  logic [CNT_W-1:0] issued_cnt;
  logic             dbg_state;

  always #5 clock_n = ~clock_n;

  ddr_req_queue #(
    .DEPTH   (DEPTH),
    .MIN_GAP (MIN_GAP),
    .CNT_W   (CNT_W)
  ) dut (
    .clock_n    (clock_n),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_data   (req_data),
    .dev_busy   (dev_busy),
    .act_cmd    (act_cmd),
    .data_out   (data_out),
    .q_count    (q_count),
    .q_empty    (q_empty),
    .issued_cnt (issued_cnt),
    .dbg_state  (dbg_state)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Queue of accepted requests; a request may issue at an edge when the
  // queue held it before that edge, dev_busy is low and at least
  // MIN_GAP+1 edges have passed since the previous issue.
  logic [W-1:0]     exp_q[$];
  logic             exp_act    = 1'b0;
  input_data_type   exp_data   = '0;
  logic [CNT_W-1:0] exp_issued = '0;
  longint           cyc        = 0;
  longint           next_ok    = 0;
  bit               check_en   = 1'b0;

  int             act_times[$];
  input_data_type act_data[$];

  task automatic model_clear();
    exp_q.delete();
    exp_act    = 1'b0;
    exp_data   = '0;
    exp_issued = '0;
    next_ok    = 0;
  endtask

  always @(negedge reset_n) model_clear();

  always @(posedge clock_n) begin : model_step
    int sz;
    bit do_issue;
    bit do_acc;
    if (!reset_n) begin
      model_clear();
    end else begin
      sz       = exp_q.size();
      do_issue = (sz > 0) && !dev_busy && (cyc >= next_ok);
      do_acc   = req_valid && (sz < DEPTH);
      if (do_issue) begin
        exp_act  = 1'b1;
        exp_data = exp_q.pop_front();
        exp_issued++;
        next_ok  = cyc + MIN_GAP + 1;
      end else begin
        exp_act = 1'b0;
      end
      if (do_acc) exp_q.push_back(req_data);
    end
    cyc++;
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clock_n) begin
    if (check_en) begin
      chk("act_cmd",    act_cmd,    exp_act);
      chk("data_out",   data_out,   exp_data);
      chk("q_count",    q_count,    exp_q.size());
      chk("q_empty",    q_empty,    exp_q.size() == 0);
      chk("req_ready",  req_ready,  exp_q.size() < DEPTH);
      chk("issued_cnt", issued_cnt, exp_issued);
      if (act_cmd === 1'b1) begin
        act_times.push_back(int'(cyc));
        act_data.push_back(data_out);
      end
    end
  end

  // ---------------- driver tasks ----------------
  function automatic input_data_type mk(input logic [31:0] a, input logic [63:0] d, input rw_type rw);
    input_data_type r;
    r.physical_addr = a;
    r.data_wr       = d;
    r.rw            = rw;
    return r;
  endfunction

  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic push(input input_data_type d);
    bit r;
    bit ok;
    ok        = 1'b0;
    req_valid = 1'b1;
    req_data  = d;
    for (int t = 0; t < 400; t++) begin
      r = req_ready;
      @(negedge clock_n);
      if (r) begin
        ok = 1'b1;
        break;
      end
    end
    req_valid = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL push_timeout: got not accepted expected accepted within 400 cycles");
    end
  endtask

  // ---------------- stimulus ----------------
  logic [31:0] t2_addr [4];
  bit          r_prev;

  initial begin
    t2_addr[0] = 32'h2000a011;
    t2_addr[1] = 32'h2000a051;
    t2_addr[2] = 32'h2000a011;
    t2_addr[3] = 32'h3000c021;

    // Reset state
    repeat (3) @(negedge clock_n);
    chk("rst_q_count",    q_count,    4'd0);
    chk("rst_q_empty",    q_empty,    1'b1);
    chk("rst_req_ready",  req_ready,  1'b1);
    chk("rst_act_cmd",    act_cmd,    1'b0);
    chk("rst_data_out",   data_out,   '0);
    chk("rst_issued_cnt", issued_cnt, 4'd0);
    reset_n  = 1'b1;
    check_en = 1'b1;
    @(negedge clock_n);

    // 1: single push, issue two edges later
    push(mk(32'h2000a011, 64'h0000a0110000a011, WRITE));
    chk("t1_act_edge1", act_cmd, 1'b0);
    @(negedge clock_n);
    chk("t1_act_edge2", act_cmd, 1'b1);
    chk("t1_data_out",  data_out, {32'h2000a011, 64'h0000a0110000a011, 1'b0});
    chk("t1_issued",    issued_cnt, 4'd1);
    chk("t1_q_empty",   q_empty, 1'b1);
    @(negedge clock_n);
    chk("t1_act_edge3", act_cmd, 1'b0);

    // 2: four back-to-back pushes, issues MIN_GAP+1 apart in order
    repeat (12) @(negedge clock_n);
    act_times.delete();
    act_data.delete();
    push(mk(32'h2000a011, 64'h1111, WRITE));
    push(mk(32'h2000a051, 64'h2222, WRITE));
    push(mk(32'h2000a011, 64'h3333, READ));
    push(mk(32'h3000c021, 64'h4444, WRITE));
    repeat (40) @(negedge clock_n);
    chk("t2_pulses", act_times.size(), 4);
    for (int i = 0; i < act_times.size() && i < 4; i++) begin
      chk("t2_addr", act_data[i].physical_addr, t2_addr[i]);
      if (i > 0) chk("t2_spacing", act_times[i] - act_times[i-1], 9);
    end
    if (act_data.size() > 2) chk("t2_read_rw", act_data[2].rw, 1'b1);

    // 3/4: fill while busy, hold a 9th, release busy
    repeat (12) @(negedge clock_n);
    dev_busy = 1'b1;
    for (int i = 0; i < 8; i++)
      push(mk(32'h4000_0000 + i, {$urandom, $urandom}, rw_type'(i % 2)));
    chk("t3_q_count_full", q_count, 4'd8);
    chk("t3_req_ready",    req_ready, 1'b0);
    req_valid = 1'b1;
    req_data  = mk(32'h4000_0008, 64'h9999, READ);
    repeat (3) @(negedge clock_n);
    chk("t3_held_q_count", q_count, 4'd8);
    dev_busy = 1'b0;
    @(negedge clock_n);
    chk("t4_act",       act_cmd, 1'b1);
    chk("t4_q_count7",  q_count, 4'd7);
    chk("t4_req_ready", req_ready, 1'b1);
    @(negedge clock_n);
    chk("t4_q_count8",  q_count, 4'd8);
    req_valid = 1'b0;
    repeat (100) @(negedge clock_n);
    chk("t3_drained", q_empty, 1'b1);
    chk("t3_issued",  issued_cnt, 4'd14);

    // 5: reset mid-operation
    dev_busy = 1'b1;
    for (int i = 0; i < 3; i++) push(mk(32'h5000_0000 + i, 64'h5, WRITE));
    dev_busy = 1'b0;
    @(posedge clock_n);
    #1;
    chk("t5_act_before", act_cmd, 1'b1);
    reset_n = 1'b0;
    #1;
    chk("t5_act_async", act_cmd, 1'b0);
    chk("t5_q_count_async", q_count, 4'd0);
    repeat (3) @(negedge clock_n);
    act_times.delete();
    reset_n = 1'b1;
    chk("t5_q_count", q_count, 4'd0);
    chk("t5_issued",  issued_cnt, 4'd0);
    repeat (20) @(negedge clock_n);
    chk("t5_no_spurious", act_times.size(), 0);

    // 6: 17 issues wrap a 4-bit counter to 1
    for (int i = 0; i < 17; i++) push(mk($urandom, {$urandom, $urandom}, rw_type'($urandom_range(0, 1))));
    repeat (120) @(negedge clock_n);
    chk("t6_wrap", issued_cnt, 4'd1);
    chk("t6_empty", q_empty, 1'b1);

    // Randomized traffic; a refused offer is held stable
    r_prev = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      if (!(req_valid && !r_prev)) begin
        req_valid = (c < 750) ? 1'($urandom_range(0, 1)) : 1'($urandom_range(0, 11) == 0);
        req_data  = mk($urandom, {$urandom, $urandom}, rw_type'($urandom_range(0, 1)));
      end
      dev_busy = ($urandom_range(0, 3) == 0);
      r_prev   = req_ready;
      @(negedge clock_n);
    end
    req_valid = 1'b0;
    dev_busy  = 1'b0;
    repeat (100) @(negedge clock_n);
    check_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
